// File: rtl/fir_cmplx_pkg.sv
// rtl/fir_cmplx_pkg.sv - shared constants, fixed-point helpers and channel coefficients for fir_cmplx
package fir_cmplx_pkg;

    localparam int DATA_SIZE = 32;
    localparam int BITS      = 10;
    localparam int TAPS      = 20;
    localparam int DECIM     = 10;

    typedef logic signed [DATA_SIZE-1:0]   sample_t;
    typedef logic signed [2*DATA_SIZE-1:0] prod_t;

    typedef enum logic [1:0] {
        FILL,
        MAC,
        WRITE
    } state_t;

    localparam prod_t DQ_BIAS = prod_t'((1 << BITS) - 1);

    function automatic sample_t quantize(input sample_t v);
        return sample_t'(v <<< BITS);
    endfunction

    // Biasing negatives before the shift makes the divide round toward zero.
    function automatic sample_t dequantize(input prod_t v);
        prod_t biased;
        biased = v[2*DATA_SIZE-1] ? v + DQ_BIAS : v;
        biased = biased >>> BITS;
        return biased[DATA_SIZE-1:0];
    endfunction

    localparam sample_t CHANNEL_COEFFS_REAL [TAPS] = '{
        1, 8, -13, 9, 11, -45, 69, -45, -79, 100,
        599, -79, -45, 69, -45, 11, 9, -13, 8, 1
    };

    localparam sample_t CHANNEL_COEFFS_IMAG [TAPS] = '{
        0, 3, -5, 7, -2, 12, -20, 31, -17, 50,
        44, -9, 6, -4, 2, -1, 0, 1, -2, 0
    };

endpackage

// File: rtl/fir_cmplx_mac.sv
// rtl/fir_cmplx_mac.sv - combinational complex multiply and dequantize of one filter tap
module fir_cmplx_mac
    import fir_cmplx_pkg::*;
(
    input  sample_t xr,
    input  sample_t xi,
    input  sample_t hr,
    input  sample_t hi,
    output sample_t dr,
    output sample_t di
);

    prod_t p_rr;
    prod_t p_ii;
    prod_t p_ri;
    prod_t p_ir;

    assign p_rr = prod_t'(hr) * prod_t'(xr);
    assign p_ii = prod_t'(hi) * prod_t'(xi);
    assign p_ri = prod_t'(hr) * prod_t'(xi);
    assign p_ir = prod_t'(hi) * prod_t'(xr);

    // Each product is dequantized on its own before combining, matching the software model.
    assign dr = dequantize(p_rr) - dequantize(p_ii);
    assign di = dequantize(p_ri) + dequantize(p_ir);

endmodule

// File: rtl/fir_cmplx.sv
// rtl/fir_cmplx.sv - complex decimating FIR channel filter between IQ FIFOs and output FIFOs
module fir_cmplx
    import fir_cmplx_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_empty,
    input  logic                        q_empty,
    output logic                        in_rd_en,
    input  logic signed [DATA_SIZE-1:0] i_in,
    input  logic signed [DATA_SIZE-1:0] q_in,
    input  logic                        real_full,
    input  logic                        imag_full,
    output logic                        out_wr_en,
    output logic signed [DATA_SIZE-1:0] real_out,
    output logic signed [DATA_SIZE-1:0] imag_out
);

    localparam int TAP_W = $clog2(TAPS);
    localparam int CNT_W = $clog2(DECIM + 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);

    state_t            state;
    sample_t           xr [TAPS];
    sample_t           xi [TAPS];
    sample_t           acc_r;
    sample_t           acc_i;
    logic [TAP_W-1:0]  tap;
    logic [CNT_W-1:0]  count;
    sample_t           d_r;
    sample_t           d_i;
    logic              pop;

    // I and Q always pop together, and only when both have data.
    assign pop      = (state == FILL) && !i_empty && !q_empty;
    assign in_rd_en = pop;

    fir_cmplx_mac u_mac (
        .xr (xr[tap]),
        .xi (xi[tap]),
        .hr (CHANNEL_COEFFS_REAL[tap]),
        .hi (CHANNEL_COEFFS_IMAG[tap]),
        .dr (d_r),
        .di (d_i)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            acc_r     <= '0;
            acc_i     <= '0;
            tap       <= '0;
            count     <= '0;
            out_wr_en <= 1'b0;
            real_out  <= '0;
            imag_out  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                xr[i] <= '0;
                xi[i] <= '0;
            end
        end else begin
            out_wr_en <= 1'b0;
            case (state)
                FILL: begin
                    if (pop) begin
                        xr[0] <= i_in;
                        xi[0] <= q_in;
                        for (int i = TAPS - 1; i > 0; i--) begin
                            xr[i] <= xr[i-1];
                            xi[i] <= xi[i-1];
                        end
                        if (count == LAST_CNT) begin
                            count <= '0;
                            tap   <= '0;
                            acc_r <= '0;
                            acc_i <= '0;
                            state <= MAC;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc_r <= acc_r + d_r;
                    acc_i <= acc_i + d_i;
                    if (tap == LAST_TAP) begin
                        tap   <= '0;
                        state <= WRITE;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                WRITE: begin
                    // Either full flag blocks both pushes so the pair stays aligned.
                    if (!real_full && !imag_full) begin
                        out_wr_en <= 1'b1;
                        real_out  <= acc_r;
                        imag_out  <= acc_i;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_cmplx.sv
// tb/tb_fir_cmplx.sv - self-checking bench for fir_cmplx with FIFO models and convolution reference
module tb_fir_cmplx;
    import fir_cmplx_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_empty, q_empty, in_rd_en;
    logic signed [31:0] i_in, q_in;
    logic        real_full, imag_full, out_wr_en;
    logic signed [31:0] real_out, imag_out;

    always #5 clock = ~clock;

    fir_cmplx dut (
        .clock     (clock),
        .reset     (reset),
        .i_empty   (i_empty),
        .q_empty   (q_empty),
        .in_rd_en  (in_rd_en),
        .i_in      (i_in),
        .q_in      (q_in),
        .real_full (real_full),
        .imag_full (imag_full),
        .out_wr_en (out_wr_en),
        .real_out  (real_out),
        .imag_out  (imag_out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fifo_i[$], fifo_q[$];
    int got_r[$], got_i[$], got_cyc[$];
    int hist_r[$], hist_i[$];
    int exp_r[$], exp_i[$];
    bit hold_i, hold_q, hold_rf, hold_if;
    int cyc = 0;
    int pops = 0;
    int rd_seen = 0;
    int first_pop = 0;
    int rd_viol = 0;

    typedef struct {
        string name;
        int    pos;
        int    iv;
        int    qv;
        int    er;
        int    ei;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int dq(input longint p);
        return int'(p / (longint'(1) <<< BITS));
    endfunction

    // Output n is the convolution of the coefficients with the samples ending at pair n*DECIM+DECIM-1.
    task automatic model_push(input int r, input int i);
        int n, ar, ai;
        longint x_r, x_i, h_r, h_i;
        hist_r.push_back(r);
        hist_i.push_back(i);
        if (hist_r.size() % DECIM == 0) begin
            n  = hist_r.size() / DECIM - 1;
            ar = 0;
            ai = 0;
            for (int k = 0; k < TAPS; k++) begin
                int idx;
                idx = n * DECIM + DECIM - 1 - k;
                x_r = (idx >= 0) ? longint'(hist_r[idx]) : 0;
                x_i = (idx >= 0) ? longint'(hist_i[idx]) : 0;
                h_r = longint'(CHANNEL_COEFFS_REAL[k]);
                h_i = longint'(CHANNEL_COEFFS_IMAG[k]);
                ar += dq(h_r * x_r) - dq(h_i * x_i);
                ai += dq(h_r * x_i) + dq(h_i * x_r);
            end
            exp_r.push_back(ar);
            exp_i.push_back(ai);
        end
    endtask

    task automatic drive();
        i_empty   = hold_i || (fifo_i.size() == 0);
        q_empty   = hold_q || (fifo_q.size() == 0);
        i_in      = (fifo_i.size() > 0) ? fifo_i[0] : 0;
        q_in      = (fifo_q.size() > 0) ? fifo_q[0] : 0;
        real_full = hold_rf;
        imag_full = hold_if;
    endtask

    task automatic push_pair(input int r, input int i);
        fifo_i.push_back(r);
        fifo_q.push_back(i);
        model_push(r, i);
        drive();
    endtask

    task automatic step();
        bit rd;
        @(negedge clock);
        rd = in_rd_en;
        if (rd && (i_empty || q_empty)) rd_viol++;
        if (rd) rd_seen++;
        if (rd && pops == 0) first_pop = cyc;
        if (out_wr_en) begin
            got_r.push_back(real_out);
            got_i.push_back(imag_out);
            got_cyc.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (rd && fifo_i.size() > 0 && fifo_q.size() > 0) begin
            void'(fifo_i.pop_front());
            void'(fifo_q.pop_front());
            pops++;
        end
        drive();
    endtask

    task automatic clear_all();
        fifo_i.delete(); fifo_q.delete();
        got_r.delete(); got_i.delete(); got_cyc.delete();
        hist_r.delete(); hist_i.delete();
        exp_r.delete(); exp_i.delete();
        hold_i = 0; hold_q = 0; hold_rf = 0; hold_if = 0;
        pops = 0; rd_seen = 0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input int budget, input string name);
        int b;
        b = 0;
        while (got_r.size() < n && b < budget) begin
            step();
            b++;
        end
        if (got_r.size() < n) check({name, "_timeout"}, got_r.size(), n);
    endtask

    function automatic int rand_sample();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 40000)) - 20000;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int target, b;
        tv[0] = '{"impulse_i",     0,  1024,     0,  100,  50};
        tv[1] = '{"impulse_q",     0,     0,  1024,  -50, 100};
        tv[2] = '{"neg_trunc_i",   9,    -1,     0,    0,   0};
        tv[3] = '{"neg_trunc_q",   9,     0,    -1,    0,   0};
        tv[4] = '{"neg_two",       9, -2048,     0,   -2,   0};
        tv[5] = '{"neg_frac",      0, -1500,     0, -146, -73};
        tv[6] = '{"tap1_mixed",    8, -1024,  2048,  -14,  13};

        reset = 1'b1;
        clear_all();
        #1;
        check("reset_in_rd_en", in_rd_en, 0);
        check("reset_out_wr_en", out_wr_en, 0);
        check("reset_real_out", real_out, 0);
        check("reset_imag_out", imag_out, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int p = 0; p < DECIM; p++)
                push_pair((p == tv[v].pos) ? tv[v].iv : 0, (p == tv[v].pos) ? tv[v].qv : 0);
            wait_outputs(1, 100, tv[v].name);
            repeat (5) step();
            check({tv[v].name, "_count"}, got_r.size(), 1);
            if (got_r.size() > 0) begin
                check({tv[v].name, "_real"}, got_r[0], tv[v].er);
                check({tv[v].name, "_imag"}, got_i[0], tv[v].ei);
                check({tv[v].name, "_latency"}, got_cyc[0] - first_pop, DECIM + TAPS + 1);
            end
        end

        do_reset();
        hold_rf = 1;
        for (int p = 0; p < DECIM; p++) push_pair((p == 0) ? 1024 : 0, 0);
        repeat (DECIM + TAPS + 15) step();
        check("bp_no_write", got_r.size(), 0);
        check("bp_rd_count", rd_seen, DECIM);
        check("bp_real_stable", real_out, 0);
        hold_rf = 0;
        drive();
        step();
        check("bp_not_early", got_r.size(), 0);
        step();
        check("bp_write_after_release", got_r.size(), 1);
        if (got_r.size() > 0) begin
            check("bp_real", got_r[0], 100);
            check("bp_imag", got_i[0], 50);
        end
        repeat (4) step();
        check("bp_real_held", real_out, 100);
        check("bp_single_pulse", got_r.size(), 1);

        do_reset();
        for (int p = 0; p < 5; p++) fifo_i.push_back(rand_sample());
        drive();
        rd_seen = 0;
        repeat (10) step();
        check("starve_no_rd", rd_seen, 0);
        check("starve_i_kept", fifo_i.size(), 5);
        for (int p = 0; p < 5; p++) begin
            fifo_q.push_back(rand_sample());
            model_push(fifo_i[p], fifo_q[p]);
        end
        for (int p = 5; p < 100; p++) push_pair(rand_sample(), rand_sample());
        b = 0;
        while (got_r.size() < 10 && b < 3000) begin
            hold_i  = ($urandom_range(0, 7) == 0);
            hold_q  = ($urandom_range(0, 7) == 0);
            hold_rf = ($urandom_range(0, 5) == 0);
            hold_if = ($urandom_range(0, 5) == 0);
            drive();
            step();
            b++;
        end
        hold_i = 0; hold_q = 0; hold_rf = 0; hold_if = 0;
        drive();
        check("rand_count", got_r.size(), 10);
        check("rd_while_empty", rd_viol, 0);
        for (int n = 0; n < 10 && n < got_r.size(); n++) begin
            check($sformatf("rand_real_%0d", n), got_r[n], exp_r[n]);
            check($sformatf("rand_imag_%0d", n), got_i[n], exp_i[n]);
        end

        got_r.delete(); got_i.delete(); got_cyc.delete();
        target = pops + DECIM;
        for (int p = 0; p < DECIM; p++) push_pair(rand_sample(), rand_sample());
        b = 0;
        while (pops < target && b < 100) begin
            step();
            b++;
        end
        check("midmac_pops", pops, target);
        repeat (7) step();
        reset = 1'b1;
        #1;
        check("midmac_out_wr_en", out_wr_en, 0);
        check("midmac_real_out", real_out, 0);
        check("midmac_imag_out", imag_out, 0);
        check("midmac_in_rd_en", in_rd_en, 0);
        check("midmac_no_partial", got_r.size(), 0);
        do_reset();
        for (int p = 0; p < DECIM; p++) push_pair(rand_sample(), rand_sample());
        wait_outputs(1, 100, "fresh");
        if (got_r.size() > 0) begin
            check("fresh_real", got_r[0], exp_r[0]);
            check("fresh_imag", got_i[0], exp_i[0]);
            check("fresh_latency", got_cyc[0] - first_pop, DECIM + TAPS + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
